// File: rtl/tt_io_sequencer.sv
// Stimulus/response replay engine for the Tiny Tapeout user pins: buffers vectors,
// drives ui/uio, checks uo after LATENCY cycles. Define TT_IO_SIG_EN to add a MISR on `sig`.
module tt_io_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WIDTH-1:0]         load_ui,
    input  logic [WIDTH-1:0]         load_uio,
    input  logic [WIDTH-1:0]         load_exp,
    input  logic [WIDTH-1:0]         load_mask,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         ui_drv,
    output logic [WIDTH-1:0]         uio_drv,
    input  logic [WIDTH-1:0]         uo_obs,
    output logic [15:0]              err_count,
    output logic [$clog2(DEPTH):0]   first_err,
    output logic [WIDTH-1:0]         sig
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [WIDTH-1:0] ui_mem   [DEPTH];
    logic [WIDTH-1:0] uio_mem  [DEPTH];
    logic [WIDTH-1:0] exp_mem  [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];

    state_t            state_q, state_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  ui_drv_q, ui_drv_d;
    logic [WIDTH-1:0]  uio_drv_q, uio_drv_d;
    logic [AW-1:0]     tag_q [LATENCY];
    logic [AW-1:0]     tag_d [LATENCY];
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [15:0]       err_q, err_d;
    logic [AW:0]       first_err_q, first_err_d;
    logic              load_ready_q, load_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              load_acc;
    logic              advance;
    logic              push;
    logic [AW-1:0]     push_idx;
    logic              cmp_en;
    logic [AW-1:0]     tag_out;
    logic [WIDTH-1:0]  diff;

`ifdef TT_IO_SIG_EN
    // Fibonacci feedback taps; WIDTH=8 realises x^8+x^6+x^5+x^4+1.
    localparam logic [WIDTH-1:0] SIG_TAPS =
        WIDTH'((WIDTH == 16) ? 32'h0000_D008 : (WIDTH == 4) ? 32'h0000_000C : 32'h0000_00B8);

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        return {s[WIDTH-2:0], ^(s & SIG_TAPS)} ^ d;
    endfunction

    logic [WIDTH-1:0] sig_q, sig_d;
`endif

    assign tag_out = tag_q[LATENCY-1];
    assign diff    = (uo_obs ^ exp_mem[tag_out]) & mask_mem[tag_out];
    assign cmp_en  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && ena && vld_q[LATENCY-1];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        ui_drv_d    = ui_drv_q;
        uio_drv_d   = uio_drv_q;
        tag_d       = tag_q;
        vld_d       = vld_q;
        err_d       = err_q;
        first_err_d = first_err_q;
`ifdef TT_IO_SIG_EN
        sig_d       = sig_q;
`endif
        load_acc    = (state_q == S_IDLE) && load_valid && load_ready_q;
        advance     = 1'b0;
        push        = 1'b0;
        push_idx    = idx_q;

        case (state_q)
            S_IDLE: begin
                if (load_acc) count_d = count_q + CNT_ONE;
                if (start) begin
                    err_d       = '0;
                    first_err_d = '0;
`ifdef TT_IO_SIG_EN
                    sig_d       = '0;
`endif
                    if (count_d == '0) begin
                        state_d = S_DONE;
                    end else begin
                        advance  = 1'b1;
                        push     = 1'b1;
                        push_idx = '0;
                        // Vector 0 may be written on this very edge; forward it.
                        ui_drv_d  = (load_acc && count_q == '0) ? load_ui  : ui_mem[0];
                        uio_drv_d = (load_acc && count_q == '0) ? load_uio : uio_mem[0];
                        idx_d     = IDX_ONE;
                        state_d   = (count_d == CNT_ONE) ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (ena) begin
                    advance   = 1'b1;
                    push      = 1'b1;
                    push_idx  = idx_q;
                    ui_drv_d  = ui_mem[idx_q];
                    uio_drv_d = uio_mem[idx_q];
                    idx_d     = idx_q + IDX_ONE;
                    if (({1'b0, idx_q} + CNT_ONE) == count_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ena) begin
                    advance = 1'b1;
                    if (vld_q == '0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                count_d   = '0;
                idx_d     = '0;
                ui_drv_d  = '0;
                uio_drv_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            vld_d[0] = push;
            tag_d[0] = push_idx;
            for (int j = 1; j < LATENCY; j++) begin
                vld_d[j] = vld_q[j-1];
                tag_d[j] = tag_q[j-1];
            end
        end

        if (cmp_en) begin
            if (diff != '0) begin
                err_d = sat_inc(err_q);
                if (!first_err_q[AW]) first_err_d = {1'b1, tag_out};
            end
`ifdef TT_IO_SIG_EN
            sig_d = misr_step(sig_q, uo_obs);
`endif
        end

        load_ready_d = (state_d == S_IDLE) && (count_d < DEPTH_C);
        busy_d       = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            ui_drv_q     <= '0;
            uio_drv_q    <= '0;
            vld_q        <= '0;
            for (int j = 0; j < LATENCY; j++) tag_q[j] <= '0;
            err_q        <= '0;
            first_err_q  <= '0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef TT_IO_SIG_EN
            sig_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            ui_drv_q     <= ui_drv_d;
            uio_drv_q    <= uio_drv_d;
            vld_q        <= vld_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            first_err_q  <= first_err_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef TT_IO_SIG_EN
            sig_q        <= sig_d;
`endif
        end
    end

    // Vector storage is pure data: no reset, written only on an accepted load.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            ui_mem[count_q[AW-1:0]]   <= load_ui;
            uio_mem[count_q[AW-1:0]]  <= load_uio;
            exp_mem[count_q[AW-1:0]]  <= load_exp;
            mask_mem[count_q[AW-1:0]] <= load_mask;
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ui_drv     = ui_drv_q;
    assign uio_drv    = uio_drv_q;
    assign err_count  = err_q;
    assign first_err  = first_err_q;
`ifdef TT_IO_SIG_EN
    assign sig        = sig_q;
`else
    assign sig        = '0;
`endif

endmodule

// File: doc/tt_io_sequencer.md
# tt_io_sequencer

Parametrised, synthesizable stimulus/response sequencer for the Tiny Tapeout user-project pin interface. It buffers a list of input vectors with expected outputs and replays them onto the user design's `ui_in`/`uio_in` pins. It samples `uo_out` a fixed number of cycles later and counts masked mismatches. It sits between the bench (or an on-chip self-test controller) and `tt_um_s_grundner`, replacing hand-driven pin stimulus with a self-checking replay engine.

## Interface
Parameters:
- `WIDTH`, 8: pin group width (ui, uio, uo each `WIDTH` bits).
- `DEPTH`, 16: vector buffer entries; power of two, ≥2.
- `LATENCY`, 1: cycles from drive to sample of the DUT output; 1..8.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: high = run; low = freeze RUN/DRAIN progress.
- `load_valid` in 1 / `load_ready` out 1: vector write handshake.
- `load_ui` in WIDTH: ui stimulus of vector.
- `load_uio` in WIDTH: uio stimulus of vector.
- `load_exp` in WIDTH: expected `uo_out`.
- `load_mask` in WIDTH: 1 = bit compared.
- `start` in 1: begin replay (IDLE only).
- `busy` out 1: high in RUN/DRAIN.
- `done` out 1: one-cycle pulse at end of replay.
- `ui_drv` out WIDTH / `uio_drv` out WIDTH: to DUT `ui_in`/`uio_in`.
- `uo_obs` in WIDTH: from DUT `uo_out`.
- `err_count` out 16: saturating mismatch count.
- `first_err` out $clog2(DEPTH)+1: MSB = valid flag, LSBs = index of first failing vector.
- `sig` out WIDTH: signature (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset: state IDLE; buffer count 0; all outputs 0, including `load_ready` for the reset cycle. `load_ready` = 1 from the first clock after release in IDLE.
- IDLE:
  - `load_ready` = (count < DEPTH).
  - Accepted write (`load_valid && load_ready`) stores a vector at index `count`, then increments `count`.
  - `start` moves to RUN and clears `err_count`, `first_err`, and `sig`. A `start` in the same cycle as a load accepts the load first, so the vector is included.
- RUN:
  - `load_ready` = 0; `start` ignored.
  - Each `ena`-high cycle drives vector `i` onto `ui_drv`/`uio_drv` and pushes index `i` into a LATENCY-deep tag pipeline, then increments `i`.
  - After index `count-1` is driven, go to DRAIN.
  - `count` = 0 at start goes straight to DONE.
- DRAIN: the pipeline empties over LATENCY `ena`-high cycles, then the state moves to DONE.
- Compare: when a tag emerges, the checker evaluates `(uo_obs ^ exp[tag]) & mask[tag]`.
  - Non-zero increments `err_count`, which saturates at 16'hFFFF.
  - The first non-zero result sets `first_err` = {1, tag}.
- DONE: `done` = 1 for one cycle, then IDLE. `count` resets to 0 (buffer emptied). `err_count`, `first_err`, and `sig` hold until the next `start`.
- `ena` low: the drive outputs, index, and tag pipeline hold; no compares occur. IDLE loading is unaffected.
- `rst_n` low mid-run: immediate return to reset values; partial results are lost.

## Timing
- `start` is sampled at edge E0; vector 0 appears on `ui_drv` after E0.
- Vector k (no `ena` stalls) is driven after edge E0+k and compared at edge E0+k+LATENCY.
- `done` is high in the cycle after edge E0+count+LATENCY.
- `busy` is high from E0 until `done` asserts.
- `ui_drv`/`uio_drv` hold the last driven vector through DRAIN and DONE, and return to 0 on entry to IDLE.
- Total replay latency = count + LATENCY + 1 cycles.

## Configuration
- `TT_IO_SIG_EN` defined:
  - `sig` is a WIDTH-bit MISR using a fixed primitive polynomial (WIDTH=8: x^8+x^6+x^5+x^4+1).
  - The update is `sig <= {sig[W-2:0],fb} ^ uo_obs` on every compare edge; the seed on `start` is 0.
- Undefined: `sig` tied to 0; no MISR logic.

## Test plan
- Reset then idle → all outputs 0 in reset; `load_ready`=1 one cycle after release; `busy`=0.
- Load 4 vectors `ui`=8'h01,02,03,04, DUT loopback `uo=ui`, `exp`=same, `mask`=FF, `start` → `done` at cycle 4+LATENCY+1; `err_count`=0; `first_err`=0.
- Same as above but `exp[2]`=8'h00, `mask[2]`=8'h0F → `err_count`=1, `first_err`={1,2}. Then with `mask[2]`=8'hF0 → `err_count`=0.
- Load DEPTH vectors → `load_ready`=0; an extra `load_valid` is ignored; replay compares exactly DEPTH vectors.
- During RUN, hold `ena` low 3 cycles → `ui_drv` stays frozen and `done` is delayed by exactly 3 cycles. A pulse on `rst_n` mid-run → IDLE with outputs 0.
- `start` with empty buffer → `done` 1 cycle later, `err_count`=0. With `TT_IO_SIG_EN`, the loopback run of {01,02,03,04} matches the model MISR value; without it, `sig`=0.
